// File: rtl/instr_enc_loader.sv
// rtl/instr_enc_loader.sv - encodes instruction requests and streams them into instruction memory
module instr_enc_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full,
  output logic [2:0]   count
);
  logic [W-1:0] mem [4];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'd4);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else if (clear) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop_ok)  rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

module instr_enc_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_kind,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_index,
  input  logic        req_last,
  output logic        im_we,
  input  logic        im_ready,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic [12:0] word_cnt,
  output logic        done,
  output logic        err,
  input  logic        restart
);
  localparam logic [1:0]  ST_LOAD  = 2'd0;
  localparam logic [1:0]  ST_DRAIN = 2'd1;
  localparam logic [1:0]  ST_DONE  = 2'd2;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [12:0] CAPACITY = 13'd4096;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        push;
  logic        pop;
  logic        cap_hit;
  logic        clear;
  logic        fifo_empty;
  logic        fifo_full;
  logic [2:0]  fifo_count;
  logic [32:0] fifo_head;
  logic [12:0] fill;

  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (req_kind)
      4'd0:    enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100000};
      4'd1:    enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100010};
      4'd2:    enc_word = {6'b000000, req_rs, 15'd0, 6'b001000};
      4'd3:    enc_word = {6'b001101, req_rs, req_rt, req_imm};
      4'd4:    enc_word = {6'b100011, req_rs, req_rt, req_imm};
      4'd5:    enc_word = {6'b101011, req_rs, req_rt, req_imm};
      4'd6:    enc_word = {6'b000100, req_rs, req_rt, req_imm};
      4'd7:    enc_word = {6'b001111, 5'd0, req_rt, req_imm};
      4'd8:    enc_word = {6'b000011, req_index};
      4'd9:    enc_word = {6'b110011, req_rs, req_rt, req_imm};
      4'd10:   enc_word = {6'b101101, req_rs, req_rt, req_imm};
      default: enc_legal = 1'b0;
    endcase
  end

  // Words already written plus words still queued must never exceed the memory window.
  assign fill      = word_cnt + {10'd0, fifo_count};
  assign req_ready = (state == ST_LOAD) & ~fifo_full & (fill < CAPACITY);
  assign accept    = req_valid & req_ready;
  assign push      = accept & enc_legal;
  assign cap_hit   = push & (fill == (CAPACITY - 13'd1));
  assign im_we     = ~fifo_empty;
  assign im_wdata  = fifo_head[31:0];
  assign pop       = im_we & im_ready;
  assign clear     = (state == ST_DONE) & restart;
  assign im_addr   = IM_BASE + {17'd0, word_cnt, 2'b00};
  assign done      = (state == ST_DONE);

  instr_enc_fifo #(.W(33)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .push_data ({req_last, enc_word}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Popping the entry tagged last empties the queue, so DONE can follow without an idle cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  if (accept & (req_last | cap_hit)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty | (pop & fifo_head[32])) state_nxt = ST_DONE;
      ST_DONE:  if (restart) state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_LOAD;
      word_cnt <= 13'd0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        word_cnt <= 13'd0;
        err      <= 1'b0;
      end else begin
        if (pop) word_cnt <= word_cnt + 13'd1;
        if (accept & (~enc_legal | cap_hit)) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_enc_loader.sv
// tb/tb_instr_enc_loader.sv - vector, corner-case and randomized checks of instr_enc_loader
`timescale 1ns/1ps
module tb_instr_enc_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_kind = 4'd0;
  logic [4:0]  req_rs = 5'd0;
  logic [4:0]  req_rt = 5'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [15:0] req_imm = 16'd0;
  logic [25:0] req_index = 26'd0;
  logic        req_last = 1'b0;
  logic        im_we;
  logic        im_ready = 1'b0;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic [12:0] word_cnt;
  logic        done;
  logic        err;
  logic        restart = 1'b0;

  always #5 clk = ~clk;

  instr_enc_loader dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .req_rs    (req_rs),
    .req_rt    (req_rt),
    .req_rd    (req_rd),
    .req_imm   (req_imm),
    .req_index (req_index),
    .req_last  (req_last),
    .im_we     (im_we),
    .im_ready  (im_ready),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .word_cnt  (word_cnt),
    .done      (done),
    .err       (err),
    .restart   (restart)
  );

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [11];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] q [$];
  logic [31:0] log_d [$];
  logic [31:0] log_a [$];
  int          m_cnt = 0;
  bit          m_err = 0;
  bit          m_load = 1;
  bit          mon_en = 0;
  bit          m_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: opcode/field arithmetic straight from the instruction formats.
  function automatic logic [32:0] model_enc(input logic [3:0] k, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [15:0] imm, input logic [25:0] idx);
    int unsigned r = rs;
    int unsigned t = rt;
    int unsigned d = rd;
    int unsigned im = imm;
    int unsigned op = 0;
    int unsigned w = 0;
    bit ok = 1;
    case (k)
      4'd0:  w = (r << 21) | (t << 16) | (d << 11) | 32;
      4'd1:  w = (r << 21) | (t << 16) | (d << 11) | 34;
      4'd2:  w = (r << 21) | 8;
      4'd7:  w = (15 << 26) | (t << 16) | im;
      4'd8:  w = (3 << 26) | idx;
      4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10: begin
        case (k)
          4'd3:    op = 13;
          4'd4:    op = 35;
          4'd5:    op = 43;
          4'd6:    op = 4;
          4'd9:    op = 51;
          default: op = 45;
        endcase
        w = (op << 26) | (r << 21) | (t << 16) | im;
      end
      default: ok = 0;
    endcase
    return {ok, w};
  endfunction

  task automatic model_clear();
    q.delete();
    log_d.delete();
    log_a.delete();
    m_cnt = 0;
    m_err = 0;
    m_load = 1;
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    bit exp_ready;
    logic [32:0] e;
    @(negedge clk);
    m_acc = 0;
    if (!mon_en) return;
    exp_ready = m_load && (q.size() < 4) && ((m_cnt + q.size()) < 4096);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("im_we", 32'(im_we), 32'(q.size() != 0));
    chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
    chk("im_addr", im_addr, 32'h3000 + 32'(4 * m_cnt));
    chk("err", 32'(err), 32'(m_err));
    if (m_load) chk("done_in_load", 32'(done), 32'd0);
    if (q.size() != 0) chk("im_wdata", im_wdata, q[0]);
    if (q.size() != 0 && im_ready) begin
      log_d.push_back(im_wdata);
      log_a.push_back(im_addr);
      void'(q.pop_front());
      m_cnt++;
    end
    m_acc = req_valid && exp_ready;
    if (m_acc) begin
      e = model_enc(req_kind, req_rs, req_rt, req_rd, req_imm, req_index);
      if (!e[32]) m_err = 1;
      else begin
        q.push_back(e[31:0]);
        if (m_cnt + q.size() == 4096) begin
          m_err = 1;
          m_load = 0;
        end
      end
      if (req_last) m_load = 0;
    end
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] idx,
                      input logic last);
    bit got = 0;
    req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_index = idx; req_last = last; req_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      neg();
      if (m_acc) begin
        got = 1;
        break;
      end
      pos();
    end
    pos();
    req_valid = 1'b0;
    req_last = 1'b0;
    chk("send_accept", 32'(got), 32'd1);
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int t = 0; t < 64; t++) begin
      neg();
      if (done) begin
        got = 1;
        break;
      end
      pos();
    end
    if (got) pos();
    chk("done_reached", 32'(got), 32'd1);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    neg();
    pos();
    restart = 1'b0;
    model_clear();
    neg();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_cnt", 32'(word_cnt), 32'd0);
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_ready", 32'(req_ready), 32'd1);
    pos();
  endtask

  initial begin
    int sent;
    tbl[0]  = '{4'd3,  5'd0,  5'd1, 5'd0, 16'h1234, 26'd0,       32'h34011234};
    tbl[1]  = '{4'd0,  5'd1,  5'd2, 5'd3, 16'h0000, 26'd0,       32'h00221820};
    tbl[2]  = '{4'd1,  5'd1,  5'd2, 5'd3, 16'h0000, 26'd0,       32'h00221822};
    tbl[3]  = '{4'd2,  5'd31, 5'd0, 5'd0, 16'h0000, 26'd0,       32'h03E00008};
    tbl[4]  = '{4'd7,  5'd5,  5'd1, 5'd0, 16'h1234, 26'd0,       32'h3C011234};
    tbl[5]  = '{4'd4,  5'd29, 5'd8, 5'd0, 16'h0004, 26'd0,       32'h8FA80004};
    tbl[6]  = '{4'd5,  5'd29, 5'd8, 5'd0, 16'hFFFC, 26'd0,       32'hAFA8FFFC};
    tbl[7]  = '{4'd6,  5'd1,  5'd2, 5'd0, 16'h0003, 26'd0,       32'h10220003};
    tbl[8]  = '{4'd8,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h0000C03, 32'h0C000C03};
    tbl[9]  = '{4'd9,  5'd2,  5'd3, 5'd0, 16'h0010, 26'd0,       32'hCC430010};
    tbl[10] = '{4'd10, 5'd4,  5'd5, 5'd0, 16'h00FF, 26'd0,       32'hB48500FF};

    // Reset values
    repeat (2) begin
      @(negedge clk);
      chk("rst_im_we", 32'(im_we), 32'd0);
      chk("rst_word_cnt", 32'(word_cnt), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_im_addr", im_addr, 32'h00003000);
    end
    pos();
    reset = 1'b1;
    model_clear();
    mon_en = 1;
    im_ready = 1'b1;

    // One request at a time: encoding, address and one-cycle latency
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].kind, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].idx, 1'(i == 10));
      neg();
      chk("vec_im_we", 32'(im_we), 32'd1);
      chk("vec_wdata", im_wdata, tbl[i].exp);
      chk("vec_addr", im_addr, 32'h3000 + 32'(4 * i));
      pos();
    end
    wait_done();
    chk("vec_cnt", 32'(word_cnt), 32'd11);
    do_restart();

    // add then jal(last) back to back
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0, 1'b0);
    send(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C03, 1'b1);
    wait_done();
    chk("seq2_cnt", 32'(word_cnt), 32'd2);
    chk("seq2_log_size", 32'(log_d.size()), 32'd2);
    if (log_d.size() >= 2) begin
      chk("seq2_w0", log_d[0], 32'h00221820);
      chk("seq2_a0", log_a[0], 32'h00003000);
      chk("seq2_w1", log_d[1], 32'h0C000C03);
      chk("seq2_a1", log_a[1], 32'h00003004);
    end
    do_restart();

    // Back-pressure: five lui requests against a stalled memory
    im_ready = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      req_valid = 1'b1;
      req_kind = 4'd7;
      req_rs = 5'($urandom);
      req_rt = 5'(sent);
      req_imm = 16'h0100 + 16'(sent);
      req_last = 1'(sent == 4);
      if (cyc == 8) im_ready = 1'b1;
      neg();
      if (cyc == 6) begin
        chk("bp_accepts", 32'(sent), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_head_hold", im_wdata, 32'h3C000100);
      end
      if (m_acc) sent++;
      pos();
      if (sent == 5) break;
    end
    req_valid = 1'b0;
    req_last = 1'b0;
    chk("bp_sent", 32'(sent), 32'd5);
    wait_done();
    chk("bp_cnt", 32'(word_cnt), 32'd5);
    do_restart();

    // Illegal kind, then sw; restart in LOAD ignored; illegal with last still drains
    send(4'd13, 5'd1, 5'd2, 5'd3, 16'h1, 26'd1, 1'b0);
    neg();
    chk("ill_no_write", 32'(im_we), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    pos();
    send(4'd5, 5'd29, 5'd8, 5'd0, 16'hFFFC, 26'd0, 1'b0);
    neg();
    chk("sw_word", im_wdata, 32'hAFA8FFFC);
    chk("sw_addr", im_addr, 32'h00003000);
    pos();
    restart = 1'b1;
    neg();
    pos();
    restart = 1'b0;
    neg();
    chk("restart_ignored_cnt", 32'(word_cnt), 32'd1);
    chk("restart_ignored_err", 32'(err), 32'd1);
    pos();
    send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'd0, 1'b1);
    wait_done();
    chk("ill_last_cnt", 32'(word_cnt), 32'd1);
    do_restart();

    // Reset while entries are queued
    send(4'd3, 5'd1, 5'd1, 5'd0, 16'h0001, 26'd0, 1'b0);
    send(4'd3, 5'd2, 5'd2, 5'd0, 16'h0002, 26'd0, 1'b0);
    neg();
    pos();
    im_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'd4, 5'(i), 5'(i + 1), 5'd0, 16'(i), 26'd0, 1'b0);
    neg();
    chk("pre_rst_cnt", 32'(word_cnt), 32'd2);
    pos();
    mon_en = 0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_im_we", 32'(im_we), 32'd0);
    chk("midrst_cnt", 32'(word_cnt), 32'd0);
    chk("midrst_addr", im_addr, 32'h00003000);
    @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
    mon_en = 1;
    im_ready = 1'b1;
    neg();
    chk("postrst_ready", 32'(req_ready), 32'd1);
    pos();

    // Randomized traffic against the reference model
    sent = 0;
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 6000 && sent < 300; cyc++) begin
      if (!req_valid || m_acc) begin
        req_valid = ($urandom % 4) != 0;
        req_kind = (($urandom % 8) == 0) ? 4'(11 + $urandom % 5) : 4'($urandom % 11);
        req_rs = 5'($urandom);
        req_rt = 5'($urandom);
        req_rd = 5'($urandom);
        req_imm = 16'($urandom);
        req_index = 26'($urandom);
        req_last = 1'(sent == 299);
      end
      im_ready = ($urandom % 3) != 0;
      neg();
      if (m_acc) sent++;
      pos();
    end
    req_valid = 1'b0;
    req_last = 1'b0;
    im_ready = 1'b1;
    chk("rand_sent", 32'(sent), 32'd300);
    wait_done();
    do_restart();

    // Fill the whole 4096-word window without a last marker
    for (int cyc = 0; cyc < 20000 && m_load; cyc++) begin
      req_valid = 1'b1;
      req_kind = 4'($urandom % 11);
      req_rs = 5'($urandom);
      req_rt = 5'($urandom);
      req_rd = 5'($urandom);
      req_imm = 16'($urandom);
      req_index = 26'($urandom);
      req_last = 1'b0;
      im_ready = ($urandom % 4) != 0;
      neg();
      pos();
    end
    im_ready = 1'b1;
    neg();
    chk("cap_ready_low", 32'(req_ready), 32'd0);
    chk("cap_err", 32'(err), 32'd1);
    pos();
    req_valid = 1'b0;
    wait_done();
    chk("cap_cnt", 32'(word_cnt), 32'd4096);
    chk("cap_done", 32'(done), 32'd1);
    chk("cap_log_size", 32'(log_a.size()), 32'd4096);
    if (log_a.size() != 0) chk("cap_last_addr", log_a[log_a.size() - 1], 32'h00006FFC);
    do_restart();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
